multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core (R-type, ADDI, LW, SW, BEQ).
//  Sequences the shared ALU, memory port, IR, PC and register file one step per state.
//  Issues ALUOp to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
//  Owns the memory request handshake, a memory-timeout watchdog and a retired-instruction counter.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles a memory state waits for mem_ready_i before aborting (>=2)
//  CNT_W           32   width of instret_o
// PORTS
//  clk             in   1      single clock; all state changes on its rising edge
//  rst_n           in   1      reset; synchronous, active-low
//  run_i           in   1      1 = execute; sampled only in IDLE and at instruction boundaries
//  opcode_i        in   7      IR[6:0], valid from DECODE onward
//  mem_ready_i     in   1      memory completes the current request this cycle
//  mem_req_o       out  1      memory request active
//  mem_we_o        out  1      request is a write
//  IorD_o          out  1      0 = address from PC, 1 = address from ALUOut
//  IRWrite_o       out  1      load IR from memory data
//  PCWrite_o       out  1      unconditional PC load
//  PCWriteCond_o   out  1      PC load if ALU zero
//  PCSource_o      out  1      0 = ALU result, 1 = ALUOut
//  ALUSrcA_o       out  2      00 = PC, 01 = reg A, 10 = OldPC
//  ALUSrcB_o       out  2      00 = reg B, 01 = const 4, 10 = imm
//  ALUOp_o         out  2      to ALU decoder
//  RegWrite_o      out  1      register file write
//  MemtoReg_o      out  1      1 = write-back from MDR, 0 = from ALUOut
//  busy_o          out  1      1 in any state other than IDLE/TRAP
//  err_o           out  1      sticky memory timeout; cleared only by reset
//  illegal_o       out  1      sticky illegal opcode (see CONFIGURATION)
//  instret_o       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (rst_n = 0 at a clock edge) sets state = IDLE, wait counter = 0, err_o = illegal_o = 0, instret_o = 0.
//  All outputs are 0 in IDLE. Outputs are Moore (decoded from registered state) unless marked "on ready".
//  States and transitions:
//   IDLE:     run_i = 1 -> FETCH.
//   FETCH:    mem_req, IorD = 0, ALUSrcA = 00, ALUSrcB = 01, ALUOp = 00.
//             On ready: IRWrite = 1, PCWrite = 1, PCSource = 0; then -> DECODE.
//   DECODE:   ALUSrcA = 10, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut).
//             Dispatch: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH; other -> see CONFIGURATION.
//   EXEC_R:   ALUSrcA = 01, ALUSrcB = 00, ALUOp = 10 -> ALU_WB.
//   EXEC_I:   ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00 -> ALU_WB.
//   ALU_WB:   RegWrite = 1, MemtoReg = 0 -> retire.
//   MEM_ADDR: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00 -> MEM_READ (LW) or MEM_WRITE (SW).
//   MEM_READ: mem_req, IorD = 1. On ready -> MEM_WB.
//   MEM_WB:   RegWrite = 1, MemtoReg = 1 -> retire.
//   MEM_WRITE: mem_req, mem_we, IorD = 1. On ready -> retire.
//   BRANCH:   ALUSrcA = 01, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 1 -> retire.
//  Retire: instret_o += 1 (wraps modulo 2^CNT_W); next state = FETCH if run_i = 1, else IDLE.
//  Zero-wait latency: BEQ 3 cycles, R/ADDI/SW 4 cycles, LW 5 cycles. Each ready-wait adds 1 cycle per stall cycle.
//  Watchdog:
//   Counter clears on entry to FETCH, MEM_READ and MEM_WRITE; it increments each cycle in those states without ready.
//   Ready arriving on the cycle the count reaches TIMEOUT_CYCLES-1 is accepted.
//   Otherwise, at that count: err_o <= 1, state -> IDLE, no retire, no writes issued that cycle.
//  run_i deassert mid-instruction: the instruction completes; the FSM stops at the boundary.
//  Reset mid-instruction: abandoned immediately; no further strobes after that edge.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   Unknown opcode in DECODE -> TRAP; illegal_o <= 1.
//   TRAP holds all strobes 0 and busy_o = 0, and is left only by reset.
//  ILLEGAL_TRAP_EN undefined:
//   Unknown opcode in DECODE -> FETCH (executes as NOP; PC already advanced); instret_o not incremented.
//   illegal_o is tied to 0.
// TESTING
//  Reset, run_i = 1, opcode 0110011, ready always 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; ALUOp 00, 00, 10, 00;
//   RegWrite only in cycle 4; instret_o = 1.
//  LW with ready delayed 3 cycles in MEM_READ -> 8 cycles total; mem_req/IorD = 1 held throughout; MemtoReg = RegWrite = 1 in MEM_WB.
//  BEQ -> 3 cycles; BRANCH asserts ALUOp = 01, PCWriteCond = 1, PCSource = 1; SW asserts mem_we only in MEM_WRITE.
//  TIMEOUT_CYCLES = 4, ready never -> err_o = 1 after 4 FETCH cycles; IDLE; instret_o unchanged; run_i ignored until reset.
//  Opcode 1111111 -> with ILLEGAL_TRAP_EN: TRAP, illegal_o = 1, strobes 0 for 20 cycles;
//   without it: next state FETCH, instret_o unchanged.
//  run_i dropped during EXEC_R -> ALU_WB completes, then IDLE; CNT_W = 4 with 16 retires -> instret_o wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Optional illegal-opcode trap: define ILLEGAL_TRAP_EN.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [6:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             PCSource_o,
  output logic [1:0]       ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_TRAP
  } state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wcnt;
  logic          wait_st;
  logic          timeout;
  logic          retire;
  logic [CNT_W-1:0] instret;
  logic          err;

  // Memory-wait states share one watchdog counter.
  assign wait_st = (state == S_FETCH) || (state == S_MEM_READ)
                || (state == S_MEM_WRITE);
  assign timeout = wait_st && !mem_ready_i && (wcnt == WLAST);

  assign instret_o = instret;
  assign err_o     = err;

`ifdef ILLEGAL_TRAP_EN
  logic trap_set;
  logic ill;
  assign illegal_o = ill;
`else
  assign illegal_o = 1'b0;
`endif

  // Next-state and Moore/on-ready control decode.
  always_comb begin
    state_nx      = state;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 1'b0;
    ALUSrcA_o     = 2'b00;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    RegWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    retire        = 1'b0;
    busy_o        = (state != S_IDLE) && (state != S_TRAP);
`ifdef ILLEGAL_TRAP_EN
    trap_set      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (run_i && !err) state_nx = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        ALUSrcB_o = 2'b01;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_nx  = S_DECODE;
        end else if (timeout) begin
          state_nx  = S_IDLE;
        end
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b10;
        case (opcode_i)
          OP_R:    state_nx = S_EXEC_R;
          OP_I:    state_nx = S_EXEC_I;
          OP_LW,
          OP_SW:   state_nx = S_MEM_ADDR;
          OP_BEQ:  state_nx = S_BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nx = S_TRAP;
            trap_set = 1'b1;
`else
            state_nx = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA_o = 2'b01;
        ALUOp_o   = 2'b10;
        state_nx  = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        state_nx  = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite_o = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        state_nx  = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i)  state_nx = S_MEM_WB;
        else if (timeout) state_nx = S_IDLE;
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i)  retire   = 1'b1;
        else if (timeout) state_nx = S_IDLE;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 2'b01;
        ALUOp_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 1'b1;
        retire        = 1'b1;
      end
      S_TRAP: begin
        state_nx = S_TRAP;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (retire) state_nx = run_i ? S_FETCH : S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Watchdog: restarts on every state change, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                     wcnt <= '0;
    else if (state_nx != state)     wcnt <= '0;
    else if (wait_st && !mem_ready_i) wcnt <= wcnt + WW'(1);
  end

  // Sticky memory-timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n)       err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (!rst_n)        ill <= 1'b0;
    else if (trap_set) ill <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Runs with TIMEOUT_CYCLES=4 and CNT_W=4.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_i;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, IorD_o, IRWrite_o, PCWrite_o;
  logic       PCWriteCond_o, PCSource_o, RegWrite_o, MemtoReg_o;
  logic [1:0] ALUSrcA_o, ALUSrcB_o, ALUOp_o;
  logic       busy_o, err_o, illegal_o;
  logic [3:0] instret_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run_i(run_i),
    .opcode_i(opcode_i),
    .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .IorD_o(IorD_o),
    .IRWrite_o(IRWrite_o),
    .PCWrite_o(PCWrite_o),
    .PCWriteCond_o(PCWriteCond_o),
    .PCSource_o(PCSource_o),
    .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_o(ALUOp_o),
    .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o),
    .busy_o(busy_o),
    .err_o(err_o),
    .illegal_o(illegal_o),
    .instret_o(instret_o)
  );

  // {busy,req,we,IorD,IRW,PCW,PCWC,PCSrc,SrcA,SrcB,ALUOp,RegW,M2R}
  logic [15:0] ctrl;
  assign ctrl = {busy_o, mem_req_o, mem_we_o, IorD_o, IRWrite_o,
                 PCWrite_o, PCWriteCond_o, PCSource_o, ALUSrcA_o,
                 ALUSrcB_o, ALUOp_o, RegWrite_o, MemtoReg_o};

  localparam logic [15:0] C_IDLE   = 16'h0000;
  localparam logic [15:0] C_FETCHW = 16'hC010;
  localparam logic [15:0] C_FETCH  = 16'hCC10;
  localparam logic [15:0] C_DEC    = 16'h80A0;
  localparam logic [15:0] C_EXR    = 16'h8048;
  localparam logic [15:0] C_EXI    = 16'h8060;
  localparam logic [15:0] C_ALUWB  = 16'h8002;
  localparam logic [15:0] C_MRD    = 16'hD000;
  localparam logic [15:0] C_MWB    = 16'h8003;
  localparam logic [15:0] C_MWR    = 16'hF000;
  localparam logic [15:0] C_BR     = 16'h8344;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    run_i = 1'b0;
    opcode_i = 7'd0;
    mem_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ill", 32'(illegal_o), 0);
    chk("rst_cnt", 32'(instret_o), 0);

    // R-type, zero wait
    rst_n = 1'b1;
    run_i = 1'b1;
    mem_ready_i = 1'b1;
    opcode_i = OP_R;
    #1;
    chk("idle_run", 32'(ctrl), 32'(C_IDLE));
    tick(); chk("r_fetch", 32'(ctrl), 32'(C_FETCH));
    tick(); chk("r_dec", 32'(ctrl), 32'(C_DEC));
    tick(); chk("r_exec", 32'(ctrl), 32'(C_EXR));
    tick(); chk("r_wb", 32'(ctrl), 32'(C_ALUWB));
    chk("r_cnt_pre", 32'(instret_o), 0);
    tick(); chk("r_next", 32'(ctrl), 32'(C_FETCH));
    chk("r_cnt", 32'(instret_o), 1);

    // ADDI
    opcode_i = OP_I;
    tick(); chk("i_dec", 32'(ctrl), 32'(C_DEC));
    tick(); chk("i_exec", 32'(ctrl), 32'(C_EXI));
    tick(); chk("i_wb", 32'(ctrl), 32'(C_ALUWB));
    tick(); chk("i_cnt", 32'(instret_o), 2);

    // BEQ: 3 cycles
    opcode_i = OP_BEQ;
    tick(); chk("b_dec", 32'(ctrl), 32'(C_DEC));
    tick(); chk("b_br", 32'(ctrl), 32'(C_BR));
    tick(); chk("b_fetch", 32'(ctrl), 32'(C_FETCH));
    chk("b_cnt", 32'(instret_o), 3);

    // SW
    opcode_i = OP_SW;
    tick(); chk("s_dec", 32'(ctrl), 32'(C_DEC));
    tick(); chk("s_addr", 32'(ctrl), 32'(C_EXI));
    tick(); chk("s_write", 32'(ctrl), 32'(C_MWR));
    tick(); chk("s_fetch", 32'(ctrl), 32'(C_FETCH));
    chk("s_cnt", 32'(instret_o), 4);

    // LW, ready on the last allowed wait cycle
    opcode_i = OP_LW;
    tick(); chk("l_dec", 32'(ctrl), 32'(C_DEC));
    tick(); chk("l_addr", 32'(ctrl), 32'(C_EXI));
    tick();
    mem_ready_i = 1'b0;
    #1;
    chk("l_rd0", 32'(ctrl), 32'(C_MRD));
    tick(); chk("l_rd1", 32'(ctrl), 32'(C_MRD));
    tick(); chk("l_rd2", 32'(ctrl), 32'(C_MRD));
    tick();
    mem_ready_i = 1'b1;
    #1;
    chk("l_rd3", 32'(ctrl), 32'(C_MRD));
    chk("l_err", 32'(err_o), 0);
    tick(); chk("l_wb", 32'(ctrl), 32'(C_MWB));
    tick(); chk("l_fetch", 32'(ctrl), 32'(C_FETCH));
    chk("l_cnt", 32'(instret_o), 5);

    // run_i dropped in EXEC_R
    opcode_i = OP_R;
    tick(); chk("d_dec", 32'(ctrl), 32'(C_DEC));
    tick();
    run_i = 1'b0;
    #1;
    chk("d_exec", 32'(ctrl), 32'(C_EXR));
    tick(); chk("d_wb", 32'(ctrl), 32'(C_ALUWB));
    tick(); chk("d_idle", 32'(ctrl), 32'(C_IDLE));
    chk("d_cnt", 32'(instret_o), 6);
    tick(); chk("d_stay", 32'(ctrl), 32'(C_IDLE));

    // Counter wrap with back-to-back BEQ
    run_i = 1'b1;
    opcode_i = OP_BEQ;
    tick(); chk("w_fetch", 32'(ctrl), 32'(C_FETCH));
    for (int i = 0; i < 10; i++) begin
      tick();
      tick();
      tick();
      chk("w_cnt", 32'(instret_o), 32'((7 + i) % 16));
    end

    // Unknown opcode
    opcode_i = OP_BAD;
    tick(); chk("x_dec", 32'(ctrl), 32'(C_DEC));
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("x_trap", 32'(ctrl), 32'(C_IDLE));
    chk("x_ill", 32'(illegal_o), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("x_hold", 32'(ctrl), 32'(C_IDLE));
    end
    chk("x_ill_hold", 32'(illegal_o), 1);
`else
    chk("x_nop", 32'(ctrl), 32'(C_FETCH));
    chk("x_ill", 32'(illegal_o), 0);
`endif
    chk("x_cnt", 32'(instret_o), 0);

    // Reset mid-instruction
    rst_n = 1'b0;
    tick();
    chk("m_rst", 32'(ctrl), 32'(C_IDLE));
    chk("m_ill", 32'(illegal_o), 0);

    // Watchdog in FETCH
    rst_n = 1'b1;
    mem_ready_i = 1'b0;
    tick(); chk("t_f0", 32'(ctrl), 32'(C_FETCHW));
    tick(); chk("t_f1", 32'(ctrl), 32'(C_FETCHW));
    tick(); chk("t_f2", 32'(ctrl), 32'(C_FETCHW));
    tick(); chk("t_f3", 32'(ctrl), 32'(C_FETCHW));
    chk("t_err0", 32'(err_o), 0);
    tick(); chk("t_idle", 32'(ctrl), 32'(C_IDLE));
    chk("t_err", 32'(err_o), 1);
    chk("t_cnt", 32'(instret_o), 0);
    mem_ready_i = 1'b1;
    tick();
    tick();
    chk("t_locked", 32'(ctrl), 32'(C_IDLE));
    chk("t_err_hold", 32'(err_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
